// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers pixel/line counters from active-high hs/vs pulses in the pixel
// clock domain. Every line and frame is measured against the nominal timing.
// The decoder reports lock, the last line and frame lengths, and one-cycle
// error pulses.
//
// Parameters
//   H_TOTAL      pixel clocks per line
//   H_SYNC       hsync pulse width in clocks
//   V_TOTAL      lines per frame
//   V_SYNC       vsync pulse width in lines
//   LOCK_FRAMES  consecutive good frames required for lock (1..7)
//
// Ports
//   clk          pixel clock, rising edge
//   reset_n      asynchronous active-low reset
//   hs, vs       sync inputs (vs only changes at line starts)
//   h_count      recovered pixel index in the line (2-clock lag)
//   v_count      recovered line index in the frame (2-clock lag)
//   locked       timing verified
//   frame_start  one-cycle pulse at line 0, pixel 0
//   err          one-cycle pulse on any timing violation
//   line_len     length of the last completed line
//   frame_lines  line count of the last completed frame
//
// Handshake: there is no flow control. Every output is a plain registered
// level or pulse. It is valid on the cycle after the edge that produced it.
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hs,
    input  logic       vs,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       locked,
    output logic       frame_start,
    output logic       err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);

    localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
    localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
    localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
    localparam logic [10:0] V_SYNC_L  = 11'(V_SYNC);
    localparam logic [2:0]  LOCK_L    = 3'(LOCK_FRAMES);
    localparam logic [9:0]  CNT_MAX   = 10'h3FF;
    localparam logic [9:0]  CNT_PRE   = 10'h3FE;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // FSM state is a plainly named register so checkers can bind to it.
    state_t     state;
    state_t     state_next;
    logic [2:0] good;
    logic [2:0] good_next;

    // Input stage
    logic hs_q;
    logic hs_q_d;
    logic vs_q;
    logic vs_prev;   // vs_q as sampled at the previous hs_rise
    logic vs_pend;   // frame started, first vs-low line not yet seen

    // Event decode
    logic hs_rise;
    logic hs_fall;
    logic fs_det;

    // Measurements, widened by one bit so that 1023 + 1 does not wrap
    logic [10:0] h_len;
    logic [10:0] v_len;

    // Individual checks
    logic chk_en;
    logic len_bad;
    logic frm_bad;
    logic hsw_bad;
    logic vsw_bad;
    logic h_tout;
    logic v_tout;
    logic fail;

    function automatic logic [9:0] sat10(input logic [10:0] x);
        return x[10] ? CNT_MAX : x[9:0];
    endfunction

    // -----------------------------------------------------------------------
    // Event decode and timing checks
    // -----------------------------------------------------------------------
    always_comb begin
        hs_rise = hs_q & ~hs_q_d;
        hs_fall = ~hs_q & hs_q_d;
        fs_det  = hs_rise & vs_q & ~vs_prev;

        h_len = {1'b0, h_count} + 11'd1;
        v_len = {1'b0, v_count} + 11'd1;

        chk_en = (state != SEARCH);

        len_bad = hs_rise && (h_len != H_TOTAL_L);
        frm_bad = fs_det && (v_len != V_TOTAL_L);
        // The counter at the hs_fall detect cycle is one less than the
        // number of clocks hs was high.
        hsw_bad = hs_fall && (h_len != H_SYNC_L);
        // On the first vs-low line start, v_count still indexes the last
        // vsync line. Adding 1 gives the pulse width in lines.
        vsw_bad = hs_rise && !vs_q && vs_pend && (v_len != V_SYNC_L);
        // Timeouts fire on the edge where a counter becomes 1023. Saturation
        // keeps it there, so each fires once until the next resync.
        h_tout  = !hs_rise && (h_count == CNT_PRE);
        v_tout  = hs_rise && !fs_det && (v_count == CNT_PRE);

        fail = chk_en && (len_bad || frm_bad || hsw_bad || vsw_bad ||
                          h_tout || v_tout);
    end

    // -----------------------------------------------------------------------
    // Lock FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        good_next  = good;
        if (fail) begin
            // An error wins over a coincident frame start.
            state_next = SEARCH;
            good_next  = 3'd0;
        end else if (fs_det) begin
            case (state)
                SEARCH: begin
                    // The first frame start only resynchronises. The frame
                    // it closes was not observed from its beginning.
                    state_next = VERIFY;
                    good_next  = 3'd0;
                end
                VERIFY: begin
                    good_next = good + 3'd1;
                    if (good + 3'd1 >= LOCK_L) begin
                        state_next = LOCKED;
                    end
                end
                LOCKED: begin
                    state_next = LOCKED;
                end
                default: begin
                    state_next = SEARCH;
                    good_next  = 3'd0;
                end
            endcase
        end
    end

    // locked comes straight from the state register. It therefore drops in
    // the same cycle that err is high.
    assign locked = (state == LOCKED);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q        <= 1'b0;
            hs_q_d      <= 1'b0;
            vs_q        <= 1'b0;
            vs_prev     <= 1'b0;
            vs_pend     <= 1'b0;
            h_count     <= 10'd0;
            v_count     <= 10'd0;
            line_len    <= 10'd0;
            frame_lines <= 10'd0;
            frame_start <= 1'b0;
            err         <= 1'b0;
            state       <= SEARCH;
            good        <= 3'd0;
        end else begin
            hs_q   <= hs;
            hs_q_d <= hs_q;
            vs_q   <= vs;

            state       <= state_next;
            good        <= good_next;
            err         <= fail;
            frame_start <= fs_det;

            if (hs_rise) begin
                h_count  <= 10'd0;
                line_len <= sat10(h_len);
                vs_prev  <= vs_q;
                if (fs_det) begin
                    v_count     <= 10'd0;
                    frame_lines <= sat10(v_len);
                    vs_pend     <= 1'b1;
                end else begin
                    if (v_count != CNT_MAX) begin
                        v_count <= v_count + 10'd1;
                    end
                    if (!vs_q) begin
                        vs_pend <= 1'b0;
                    end
                end
            end else if (h_count != CNT_MAX) begin
                h_count <= h_count + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns/1ps
// Bench for vga_sync_decoder. The stream is built line by line. Each line
// start pushes its expected report into exp_q, and so does each mid-line
// error. A monitor on the falling edge pops an entry and compares it each
// time the DUT presents a line start (h_count returns to 0) or an err pulse.
module tb_vga_sync_decoder;

    localparam int H_TOTAL     = 100;
    localparam int H_SYNC      = 12;
    localparam int V_TOTAL     = 10;
    localparam int V_SYNC      = 2;
    localparam int LOCK_FRAMES = 2;

    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hs = 1'b0;
    logic       vs = 1'b0;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       locked;
    logic       frame_start;
    logic       err;
    logic [9:0] line_len;
    logic [9:0] frame_lines;

    vga_sync_decoder #(
        .H_TOTAL    (H_TOTAL),
        .H_SYNC     (H_SYNC),
        .V_TOTAL    (V_TOTAL),
        .V_SYNC     (V_SYNC),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .hs         (hs),
        .vs         (vs),
        .h_count    (h_count),
        .v_count    (v_count),
        .locked     (locked),
        .frame_start(frame_start),
        .err        (err),
        .line_len   (line_len),
        .frame_lines(frame_lines)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       is_line;
        logic       fs;
        logic       er;
        logic       chk_len;
        logic       lk;
        logic [9:0] len;
        logic [9:0] fl;
        logic [9:0] v;
        logic [9:0] h;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  rise_cyc = 0;
    bit  mon_en = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (line level) ----------------
    int m_mode, m_good, m_prev_len, m_prev_vs, m_cnt, m_fl, m_ll, m_vs_pend, m_vs_run;

    task automatic model_reset();
        m_mode = M_SEARCH; m_good = 0; m_prev_len = -1; m_prev_vs = 0;
        m_cnt = 0; m_fl = 0; m_ll = 0; m_vs_pend = 0; m_vs_run = 0;
    endtask

    function automatic int min1023(input int x);
        return (x > 1023) ? 1023 : x;
    endfunction

    task automatic push_mid(input int h);
        ev_t e;
        e = '0;
        e.is_line = 1'b0;
        e.er = 1'b1;
        e.h = 10'(h);
        exp_q.push_back(e);
        m_mode = M_SEARCH;
        m_good = 0;
    endtask

    // One line: hs high for hsw clocks, len clocks in total, vs constant.
    task automatic drive_line(input int len, input int hsw, input bit v);
        ev_t e;
        bit fs, chk, bad;
        fs  = v && (m_prev_vs == 0);
        chk = (m_mode != M_SEARCH);
        bad = 0;
        if (chk && m_prev_len != H_TOTAL) bad = 1;
        if (chk && fs && (m_cnt + 1) != V_TOTAL) bad = 1;
        if (chk && !fs && m_vs_pend != 0 && !v && m_vs_run != V_SYNC) bad = 1;
        if (chk && !fs && m_cnt == 1022) bad = 1;
        m_prev_vs = v;
        if (m_prev_len >= 0) m_ll = min1023(m_prev_len);
        if (fs) begin
            m_fl = min1023(m_cnt + 1);
            m_cnt = 0;
            m_vs_pend = 1;
            m_vs_run = 1;
        end else begin
            m_cnt = min1023(m_cnt + 1);
            if (m_vs_pend != 0) begin
                if (v) m_vs_run++;
                else m_vs_pend = 0;
            end
        end
        if (bad) begin
            m_mode = M_SEARCH;
            m_good = 0;
        end else if (fs) begin
            if (m_mode == M_SEARCH) begin
                m_mode = M_VERIFY;
                m_good = 0;
            end else if (m_mode == M_VERIFY) begin
                m_good++;
                if (m_good >= LOCK_FRAMES) m_mode = M_LOCKED;
            end
        end
        e = '0;
        e.is_line = 1'b1;
        e.fs = fs;
        e.er = bad;
        e.chk_len = (m_prev_len >= 0);
        e.lk = (m_mode == M_LOCKED);
        e.len = 10'(m_ll);
        e.fl = 10'(m_fl);
        e.v = 10'(m_cnt);
        exp_q.push_back(e);
        // A wrong hsync width shows one edge after the fall, when the
        // counter equals the width.
        if (m_mode != M_SEARCH && hsw != H_SYNC) push_mid(hsw);
        if (m_mode != M_SEARCH && len > 1100) push_mid(1023);
        m_prev_len = len;
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            hs = (c < hsw);
            vs = v;
            if (c == 0) rise_cyc = cyc;
        end
    endtask

    task automatic drive_frame(input int nlines, input int vs_lines,
                               input int bad_line, input int bad_len,
                               input int hsw_line, input int bad_hsw);
        for (int l = 0; l < nlines; l++) begin
            drive_line((l == bad_line) ? bad_len : H_TOTAL,
                       (l == hsw_line) ? bad_hsw : H_SYNC,
                       l < vs_lines);
        end
    endtask

    task automatic clean_frames(input int n);
        for (int f = 0; f < n; f++) drive_frame(V_TOTAL, V_SYNC, -1, 0, -1, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_h_count"}, h_count, 0);
        check({tag, "_v_count"}, v_count, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_line_len"}, line_len, 0);
        check({tag, "_frame_lines"}, frame_lines, 0);
    endtask

    task automatic release_reset();
        @(posedge clk); #3;
        reset_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        mon_en = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            hs = 1'b0;
            vs = 1'b0;
        end
    endtask

    // ---------------- monitor ----------------
    ev_t        mon_e;
    logic [9:0] h_prev = 10'd0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (h_count == 10'd0 && h_prev != 10'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_line_event", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("event_kind_line", 1, int'(mon_e.is_line));
                    if (mon_e.is_line) begin
                        check("rise_latency", cyc - rise_cyc, 2);
                        check("frame_start", frame_start, mon_e.fs);
                        check("err_line", err, mon_e.er);
                        if (mon_e.chk_len) check("line_len", line_len, mon_e.len);
                        check("frame_lines", frame_lines, mon_e.fl);
                        check("v_count", v_count, mon_e.v);
                        check("locked", locked, mon_e.lk);
                    end
                end
            end else if (err || frame_start) begin
                check("frame_start_mid_line", frame_start, 0);
                if (err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_err", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("event_kind_mid", 0, int'(mon_e.is_line));
                        check("err_h_count", h_count, mon_e.h);
                        check("locked_on_err", locked, 0);
                    end
                end
            end
        end
        h_prev = h_count;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        check("watchdog_timeout", 1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int nl, vl, len, hsw;
        model_reset();
        #2;
        check_all_zero("reset");
        release_reset();

        // Ideal stream: lock is expected at the third frame start.
        clean_frames(4);
        check("ideal_locked", locked, 1);
        check("ideal_line_len", line_len, H_TOTAL);
        check("ideal_frame_lines", frame_lines, V_TOTAL);

        // One short line while locked, then re-lock.
        drive_frame(V_TOTAL, V_SYNC, 4, H_TOTAL - 1, -1, 0);
        clean_frames(3);
        check("relock_after_short_line", locked, 1);

        // Narrow hsync while locked.
        drive_frame(V_TOTAL, V_SYNC, -1, 0, 3, H_SYNC - 1);
        clean_frames(3);
        check("relock_after_hsync", locked, 1);

        // vsync held for three lines.
        drive_frame(V_TOTAL, 3, -1, 0, -1, 0);
        clean_frames(3);
        check("relock_after_vsync", locked, 1);

        // Randomised perturbations.
        for (int f = 0; f < 6; f++) begin
            nl = $urandom_range(V_TOTAL + 1, V_TOTAL - 1);
            vl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : V_SYNC;
            for (int l = 0; l < nl; l++) begin
                len = H_TOTAL;
                hsw = H_SYNC;
                if ($urandom_range(0, 24) == 0) len = H_TOTAL + (($urandom_range(0, 1) == 0) ? -1 : 1);
                if ($urandom_range(0, 24) == 0) hsw = H_SYNC + (($urandom_range(0, 1) == 0) ? -1 : 1);
                drive_line(len, hsw, l < vl);
            end
        end
        clean_frames(4);
        check("relock_after_random", locked, 1);

        // Reset mid-line while locked.
        drive_line(50, H_SYNC, 1'b0);
        mon_en = 0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        hs = 1'b0;
        vs = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        release_reset();
        clean_frames(2);
        check("no_lock_after_2_fs", locked, 0);
        drive_line(H_TOTAL, H_SYNC, 1'b1);
        @(negedge clk);
        check("lock_at_3rd_fs", locked, 1);
        for (int l = 1; l < V_TOTAL; l++) drive_line(H_TOTAL, H_SYNC, l < V_SYNC);

        // hs stuck low: single timeout error, counter saturates.
        drive_line(1300, H_SYNC, 1'b0);
        @(negedge clk);
        check("h_count_saturated", h_count, 1023);
        check("locked_after_timeout", locked, 0);

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
